// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: 32-iteration shift-add multiply and
// restoring divide on operand magnitudes, with a one-cycle path for div-by-zero/overflow.
module mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  out_rd,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready
  // && !flush; a result transfers where out_valid && out_ready && !flush.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  cnt;
  logic [31:0] a_mag, b_mag;
  logic        neg_res, neg_rem;
  logic [63:0] prod;
  logic [31:0] rem;
  logic [31:0] result_q;

  logic        a_sgn, b_sgn, div_zero, div_ovf, special, accept;
  logic [31:0] a_abs, b_abs, special_res;
  logic [32:0] mul_sum, div_sh, div_diff;
  logic [63:0] mul_next, mul_fin;
  logic [31:0] quo_next, rem_next, quo_fin, rem_fin, final_res;

  always_comb begin
    a_sgn       = rs1_data[31] & !(op == 3'b011 || op == 3'b101 || op == 3'b111);
    b_sgn       = rs2_data[31] & (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
    a_abs       = a_sgn ? (~rs1_data + 32'd1) : rs1_data;
    b_abs       = b_sgn ? (~rs2_data + 32'd1) : rs2_data;
    div_zero    = op[2] && (rs2_data == 32'd0);
    div_ovf     = (op == 3'b100 || op == 3'b110) && (rs1_data == 32'h8000_0000) &&
                  (rs2_data == 32'hFFFF_FFFF);
    special     = div_zero || div_ovf;
    special_res = div_zero ? (op[1] ? rs1_data : 32'hFFFF_FFFF)
                           : (op[1] ? 32'd0 : 32'h8000_0000);
    accept      = in_valid && (state == IDLE) && !flush;
  end

  // One iteration of each algorithm; the final-result mux uses the values the
  // last iteration produces so DONE is entered on the same edge.
  always_comb begin
    mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
    mul_next  = {mul_sum, prod[31:1]};
    div_sh    = {rem, prod[31]};
    div_diff  = div_sh - {1'b0, b_mag};
    rem_next  = div_diff[32] ? div_sh[31:0] : div_diff[31:0];
    quo_next  = {prod[30:0], !div_diff[32]};
    mul_fin   = neg_res ? (~mul_next + 64'd1) : mul_next;
    quo_fin   = neg_res ? (~quo_next + 32'd1) : quo_next;
    rem_fin   = neg_rem ? (~rem_next + 32'd1) : rem_next;
    case (op_q)
      3'b000:                final_res = mul_fin[31:0];
      3'b001, 3'b010, 3'b011: final_res = mul_fin[63:32];
      3'b100, 3'b101:        final_res = quo_fin;
      default:               final_res = rem_fin;
    endcase
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_n = special ? DONE : CALC;
        CALC:    if (cnt == 5'd31) state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      cnt      <= 5'd0;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      prod     <= 64'd0;
      rem      <= 32'd0;
      result_q <= 32'd0;
    end else if (accept) begin
      op_q    <= op;
      rd_q    <= rd;
      cnt     <= 5'd0;
      a_mag   <= a_abs;
      b_mag   <= b_abs;
      neg_res <= a_sgn ^ b_sgn;
      neg_rem <= a_sgn;
      rem     <= 32'd0;
      // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
      prod    <= op[2] ? {32'd0, a_abs} : {32'd0, b_abs};
      if (special) result_q <= special_res;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 5'd1;
      if (op_q[2]) begin
        rem  <= rem_next;
        prod <= {prod[63:32], quo_next};
      end else begin
        prod <= mul_next;
      end
      if (cnt == 5'd31) result_q <= final_res;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign out_rd    = rd_q;
  assign dbg_state = state;

endmodule
